led_display_arbiter: RTL and testbench

Shares the board's 8-bit LED bank between N_REQ requesters, for example the sequence-detector result, debug status and self-test.
- A round-robin arbiter grants the bank to one requester at a time.
- The granted requester's pattern is played in one of four modes, stepped by an internal prescaled tick, for a requested number of ticks.
- The block sits between the functional blocks and the top-level LED pins.

---
 rtl/led_arb_pkg.sv | 33 +++
 rtl/led_tick_gen.sv | 25 ++
 rtl/led_display_arbiter.sv | 174 +++++++++++++++++
 tb/tb_led_display_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED display arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROT    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CNT    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Next LED value for one display step; blink alternates between pattern and dark.
  function automatic logic [LED_W-1:0] led_step(input mode_t mode,
                                                input logic [LED_W-1:0] cur,
                                                input logic [LED_W-1:0] pat);
    logic [LED_W-1:0] nxt;
    case (mode)
      MODE_ROT:   nxt = {cur[LED_W-2:0], cur[LED_W-1]};
      MODE_BLINK: nxt = (cur == pat) ? '0 : pat;
      MODE_CNT:   nxt = cur + LED_W'(1);
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Display-step prescaler: counts 0..TICK_DIV-1, tick_c_o flags the terminal count.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || tick_c_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the LED bank; plays the winner's pattern for a latched tick count.
// Optional LED_IDLE_CHASE_EN: one-hot chase on the LEDs while no requester owns the bank.
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DUR_W    = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       req_mode,
  input  logic [LED_W*N_REQ-1:0]   req_pat,
  input  logic [DUR_W*N_REQ-1:0]   req_dur,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     tick,
  output logic [LED_W-1:0]         LED
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  mode_t              mode_q;
  logic [LED_W-1:0]   pat_q;
  logic [DUR_W-1:0]   rem_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;
  logic               tick_q;
  logic [LED_W-1:0]   led_q;

  logic               tick_c;
  logic               presc_clr_c;
  logic [LED_W-1:0]   idle_led_c;
  logic [IDX_W:0]     pick_c;
  logic               win_vld_c;
  logic [IDX_W-1:0]   win_idx_c;
  mode_t              sel_mode_c;
  logic [LED_W-1:0]   sel_pat_c;
  logic [DUR_W-1:0]   sel_dur_c;
  logic               owner_req_c;

  // First set request after ptr, wrapping; MSB of the result is the valid flag.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = (int'(ptr) + k) % int'(N_REQ);
      if (r[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign pick_c      = rr_pick(req, rr_ptr_q);
  assign win_vld_c   = pick_c[IDX_W];
  assign win_idx_c   = pick_c[IDX_W-1:0];
  assign owner_req_c = |(req & grant_q);

  always_comb begin
    sel_mode_c = MODE_STATIC;
    sel_pat_c  = '0;
    sel_dur_c  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_idx_c == IDX_W'(i)) begin
        sel_mode_c = mode_t'(req_mode[2*i +: 2]);
        sel_pat_c  = req_pat[LED_W*i +: LED_W];
        sel_dur_c  = req_dur[DUR_W*i +: DUR_W];
      end
    end
  end

`ifdef LED_IDLE_CHASE_EN
  logic [LED_W-1:0] chase_q;
  logic [LED_W-1:0] chase_d;

  assign chase_d     = tick_c ? {chase_q[LED_W-2:0], chase_q[LED_W-1]} : chase_q;
  assign idle_led_c  = chase_d;
  assign presc_clr_c = (state_q == IDLE) && win_vld_c;

  // Chase restarts from bit 0 every time the bank is released.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q == RUN) begin
      chase_q <= LED_W'(1);
    end else begin
      chase_q <= chase_d;
    end
  end
`else
  assign idle_led_c  = '0;
  assign presc_clr_c = (state_q != RUN);
`endif

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .clr_i    (presc_clr_c),
    .tick_c_o (tick_c)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      mode_q   <= MODE_STATIC;
      pat_q    <= '0;
      rem_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      led_q    <= '0;
    end else begin
      done_q <= '0;
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_c) begin
            state_q  <= RUN;
            rr_ptr_q <= win_idx_c;
            mode_q   <= sel_mode_c;
            pat_q    <= sel_pat_c;
            rem_q    <= (sel_dur_c == '0) ? DUR_W'(1) : sel_dur_c;
            grant_q  <= N_REQ'(1) << win_idx_c;
            led_q    <= sel_pat_c;
            busy_q   <= 1'b1;
          end else begin
            led_q <= idle_led_c;
          end
        end
        RUN: begin
          // Abort outranks a coincident tick: a withdrawn requester never sees done.
          if (!owner_req_c) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tick_c) begin
            if (rem_q == DUR_W'(1)) begin
              state_q <= DONE;
              done_q  <= grant_q;
              grant_q <= '0;
              led_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              rem_q  <= rem_q - DUR_W'(1);
              led_q  <= led_step(mode_q, led_q, pat_q);
              tick_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          led_q   <= idle_led_c;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Bench for led_display_arbiter: directed scenarios plus randomized traffic vs. a cycle model.
module tb_led_display_arbiter;

  localparam int NR = 4;
  localparam int TD = 4;
  localparam int DW = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] req_mode;
  logic [8*NR-1:0] req_pat;
  logic [DW*NR-1:0] req_dur;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            busy;
  logic            tick;
  logic [7:0]      LED;

  led_display_arbiter #(.N_REQ(NR), .TICK_DIV(TD), .DUR_W(DW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .req_mode (req_mode),
    .req_pat  (req_pat),
    .req_dur  (req_dur),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .tick     (tick),
    .LED      (LED)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner, latched request and cycles elapsed since grant.
  bit         m_valid = 1'b0;
  int         m_state = 0;
  int         m_ptr = NR - 1;
  int         m_mode, m_dur, m_elapsed;
  logic [7:0] m_pat;
  logic [NR-1:0] e_grant, e_done;
  logic       e_busy, e_tick;
  logic [7:0] e_led;

  // LED shown after k display steps, computed directly from k.
  function automatic logic [7:0] led_after(input int md, input logic [7:0] p, input int k);
    int v, r;
    v = int'(p);
    case (md)
      1: begin r = k % 8; v = ((v << r) | (v >> (8 - r))) & 255; end
      2: v = (k % 2 == 0) ? v : 0;
      3: v = (v + k) & 255;
      default: ;
    endcase
    return 8'(v);
  endfunction

  always @(posedge sys_clk) begin
    m_valid = 1'b1;
    e_done  = '0;
    e_tick  = 1'b0;
    if (sys_rst) begin
      m_state = 0; m_ptr = NR - 1;
      e_grant = '0; e_busy = 1'b0; e_led = '0;
    end else if (m_state == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (m_state == 0 && req[c]) begin
          m_state = 1; m_ptr = c;
          m_mode = int'(req_mode[2*c +: 2]);
          m_pat  = req_pat[8*c +: 8];
          m_dur  = int'(req_dur[DW*c +: DW]);
          if (m_dur == 0) m_dur = 1;
          m_elapsed = 0;
          e_grant = NR'(1 << c); e_busy = 1'b1; e_led = m_pat;
        end
      end
    end else if (m_state == 1) begin
      m_elapsed++;
      if (!req[m_ptr]) begin
        m_state = 0; e_grant = '0; e_busy = 1'b0; e_led = '0;
      end else if (m_elapsed % TD == 0) begin
        if (m_elapsed / TD == m_dur) begin
          m_state = 2; e_done = e_grant; e_grant = '0; e_busy = 1'b0; e_led = '0;
        end else begin
          e_led = led_after(m_mode, m_pat, m_elapsed / TD);
          e_tick = 1'b1;
        end
      end
    end else begin
      m_state = 0;
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      chk("m_grant", 8'(grant), 8'(e_grant));
      chk("m_done", 8'(done), 8'(e_done));
      chk("m_busy", 8'(busy), 8'(e_busy));
      chk("m_tick", 8'(tick), 8'(e_tick));
      chk("m_led", LED, e_led);
    end
  end

  // Grants one requester and walks its display, checking each step's LED value.
  task automatic show(input int who, input logic [1:0] md, input logic [7:0] pat,
                      input logic [7:0] dur, input int nsteps, input logic [31:0] seq);
    logic [7:0] want;
    req_mode[2*who +: 2] = md;
    req_pat[8*who +: 8]  = pat;
    req_dur[DW*who +: DW] = dur;
    req = NR'(1 << who);
    @(negedge sys_clk);
    chk("show_grant", 8'(grant), 8'(1 << who));
    for (int s = 0; s < nsteps; s++) begin
      for (int c = 0; c < TD; c++) begin
        want = seq[8*s +: 8];
        chk("show_led", LED, want);
        chk("show_no_done", 8'(done), 8'h00);
        @(negedge sys_clk);
      end
    end
    chk("show_done_pulse", 8'(done), 8'(1 << who));
    chk("show_led_off", LED, 8'h00);
    chk("show_grant_off", 8'(grant), 8'h00);
    req = '0;
    @(negedge sys_clk);
    chk("show_done_clr", 8'(done), 8'h00);
  endtask

  int ord [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    sys_rst = 1'b1; req = '1; req_mode = '0;
    req_pat = {4{8'hA5}}; req_dur = {4{8'd3}};

    repeat (3) begin
      @(negedge sys_clk);
      chk("rst_led", LED, 8'h00);
      chk("rst_grant", 8'(grant), 8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("first_grant", 8'(grant), 8'h01);
    req = '0;
    @(negedge sys_clk);

    show(0, 2'b00, 8'hA5, 8'd3, 3, {8'h00, 8'hA5, 8'hA5, 8'hA5});
    show(1, 2'b01, 8'h81, 8'd4, 4, {8'h0C, 8'h06, 8'h03, 8'h81});
    show(2, 2'b11, 8'hFE, 8'd3, 3, {8'h00, 8'h00, 8'hFF, 8'hFE});
    show(3, 2'b10, 8'h3C, 8'd0, 1, {24'h0, 8'h3C});

    // Round-robin rotation with requesters holding req across displays.
    req_mode = '0; req_dur = {4{8'd1}}; req_pat = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0101;
    for (int g = 0; g < 6; g++) begin
      int gap;
      gap = 0;
      while (grant == '0 && gap < 64) begin
        @(negedge sys_clk);
        gap++;
      end
      chk("rr_order", 8'(grant), 8'(1 << ord[g]));
      if (g > 0) chk("rr_gap", 8'(gap), 8'd2);
      if (g == 0) req = 4'b0111;
      if (g == 5) req = '0;
      for (int n = 0; n < 64 && grant != '0; n++) @(negedge sys_clk);
    end
    repeat (2) @(negedge sys_clk);

    // Abort by dropping req on the 5th RUN cycle.
    req_pat[7:0] = 8'h5A; req_dur[7:0] = 8'd5; req_mode[1:0] = 2'b00;
    req = 4'b0001;
    @(negedge sys_clk);
    chk("abort_grant_on", 8'(grant), 8'h01);
    repeat (4) @(negedge sys_clk);
    req = '0;
    @(negedge sys_clk);
    chk("abort_grant", 8'(grant), 8'h00);
    chk("abort_led", LED, 8'h00);
    chk("abort_done", 8'(done), 8'h00);
    repeat (4) begin
      @(negedge sys_clk);
      chk("abort_no_done", 8'(done), 8'h00);
    end

    // Reset in the middle of a display.
    req_mode[3:2] = 2'b01; req_pat[15:8] = 8'h81; req_dur[15:8] = 8'd5;
    req = 4'b0010;
    repeat (6) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_led", LED, 8'h00);
    chk("mid_rst_grant", 8'(grant), 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_tick", 8'(tick), 8'h00);
    chk("mid_rst_done", 8'(done), 8'h00);
    sys_rst = 1'b0; req = '0;
    @(negedge sys_clk);

    // Randomized traffic; fields churn every cycle to exercise latching.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
        end
        req_dur[DW*i +: DW] = DW'($urandom_range(0, 5));
      end
      req_mode = 8'($urandom);
      req_pat  = $urandom;
      sys_rst  = ($urandom_range(0, 299) == 0);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0; req = '0;
    repeat (3) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
